gate_truth_checker: RTL and testbench

- Self-checking response monitor for two-input gate DUTs: the observing end of the stimulus/response pair.
- Each cycle a sample {a,b,y} is presented with a valid strobe.
- The block compares y against a parameterised truth table and counts samples and mismatches.
- It latches the first failing vector and reports done/pass/timeout, which lets gate benches such as the XNOR one run self-checking in simulation or on FPGA.

---
 rtl/gate_chk_pkg.sv | 22 ++
 rtl/gate_truth_checker_sat_counter.sv | 34 +++
 rtl/gate_truth_checker.sv | 141 ++++++++++++++
 tb/tb_gate_truth_checker.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and truth-table constants for the two-input gate response checker.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  // Expected y indexed by {a,b}: bit0 = a0b0 ... bit3 = a1b1.
  localparam logic [3:0] XNOR_TT = 4'b1001;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] NOR_TT  = 4'b0001;

  function automatic logic tt_lookup(input logic [3:0] tt, input logic a, input logic b);
    return tt[{a, b}];
  endfunction

endpackage

// File: rtl/gate_truth_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/gate_truth_checker.sv
// Response monitor for two-input gates: compares observed y against a truth table,
// counts samples/mismatches, latches the first failure and guards against stalls.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE = XNOR_TT,
  parameter int         NUM_VECTORS = 4,
  parameter int         CNT_W       = 8,
  parameter int         TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             smp_valid,
  input  logic             smp_a,
  input  logic             smp_b,
  input  logic             smp_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] smp_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [2:0]       first_fail_vec
);

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] WD_LIMIT  = CNT_W'(TIMEOUT - 1);

  chk_state_t       state_q, state_d;
  logic [CNT_W-1:0] smp_count_q, smp_count_d;
  logic [CNT_W-1:0] first_fail_idx_q, first_fail_idx_d;
  logic [2:0]       first_fail_vec_q, first_fail_vec_d;
  logic             timeout_q, timeout_d;
  logic             pass_q, pass_d;

  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] idle_cnt;

  logic run_start;
  logic in_run;
  logic accept;
  logic exp_y;
  logic mismatch;
  logic last_smp;
  logic wd_fire;

  assign in_run    = (state_q == RUN);
  assign run_start = !in_run && start;
  assign accept    = in_run && smp_valid;
  assign exp_y     = tt_lookup(TRUTH_TABLE, smp_a, smp_b);
  // Case inequality so an X/Z response is reported as a mismatch in simulation.
  assign mismatch  = accept && (smp_y !== exp_y);
  assign last_smp  = accept && (smp_count_q == LAST_IDX);
  // A sample on the firing edge resets the watchdog instead of tripping it.
  assign wd_fire   = in_run && !smp_valid && (idle_cnt == WD_LIMIT);

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (run_start),
    .inc_i   (mismatch),
    .count_o (err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_idle_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (run_start || accept),
    .inc_i   (in_run && !smp_valid),
    .count_o (idle_cnt)
  );

  always_comb begin
    state_d          = state_q;
    smp_count_d      = smp_count_q;
    first_fail_idx_d = first_fail_idx_q;
    first_fail_vec_d = first_fail_vec_q;
    timeout_d        = timeout_q;
    pass_d           = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d          = RUN;
          smp_count_d      = '0;
          first_fail_idx_d = '0;
          first_fail_vec_d = '0;
          timeout_d        = 1'b0;
          pass_d           = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          smp_count_d = smp_count_q + CNT_W'(1);
          if (mismatch && (err_cnt == '0)) begin
            first_fail_idx_d = smp_count_q + CNT_W'(1);
            first_fail_vec_d = {smp_a, smp_b, smp_y};
          end
          if (last_smp) begin
            state_d = DONE;
            pass_d  = (err_cnt == '0) && !mismatch;
          end
        end else if (wd_fire) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      smp_count_q      <= '0;
      first_fail_idx_q <= '0;
      first_fail_vec_q <= '0;
      timeout_q        <= 1'b0;
      pass_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      smp_count_q      <= smp_count_d;
      first_fail_idx_q <= first_fail_idx_d;
      first_fail_vec_q <= first_fail_vec_d;
      timeout_q        <= timeout_d;
      pass_q           <= pass_d;
    end
  end

  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign smp_count      = smp_count_q;
  assign err_count      = err_cnt;
  assign first_fail_idx = first_fail_idx_q;
  assign first_fail_vec = first_fail_vec_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench: an XNOR checker and an XOR checker observe the same sample stream.
module tb_gate_truth_checker;
  import gate_chk_pkg::*;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n, start, smp_valid, smp_a, smp_b, smp_y;

  logic             busy, done, pass, timeout;
  logic [CNT_W-1:0] smp_count, err_count, first_fail_idx;
  logic [2:0]       first_fail_vec;

  logic             x_busy, x_done, x_pass, x_timeout;
  logic [CNT_W-1:0] x_smp_count, x_err_count, x_first_fail_idx;
  logic [2:0]       x_first_fail_vec;

  int n_checks = 0;
  int n_miscompares = 0;

  always #5 clk = ~clk;

  gate_truth_checker #(
    .TRUTH_TABLE(XNOR_TT), .NUM_VECTORS(4), .CNT_W(CNT_W), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid),
    .smp_a(smp_a), .smp_b(smp_b), .smp_y(smp_y),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .smp_count(smp_count), .err_count(err_count),
    .first_fail_idx(first_fail_idx), .first_fail_vec(first_fail_vec)
  );

  gate_truth_checker #(
    .TRUTH_TABLE(XOR_TT), .NUM_VECTORS(4), .CNT_W(CNT_W), .TIMEOUT(16)
  ) dut_xor (
    .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid),
    .smp_a(smp_a), .smp_b(smp_b), .smp_y(smp_y),
    .busy(x_busy), .done(x_done), .pass(x_pass), .timeout(x_timeout),
    .smp_count(x_smp_count), .err_count(x_err_count),
    .first_fail_idx(x_first_fail_idx), .first_fail_vec(x_first_fail_vec)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic a, input logic b, input logic y);
    smp_valid = 1'b1;
    smp_a = a;
    smp_b = b;
    smp_y = y;
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; smp_valid = 1'b0;
    smp_a = 1'b0; smp_b = 1'b0; smp_y = 1'b0;
    idle(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_smp_count", smp_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_ff_idx", first_fail_idx, 0);
    chk("rst_ff_vec", first_fail_vec, 0);
    rst_n = 1'b1;
    tick();

    // Clean XNOR run; the XOR checker sees every response as wrong.
    pulse_start();
    chk("t1_busy", busy, 1);
    send(0, 0, 1); send(1, 0, 0); send(0, 1, 0);
    chk("t1_done_early", done, 0);
    chk("t1_count3", smp_count, 3);
    send(1, 1, 1);
    chk("t1_done", done, 1);
    chk("t1_busy_off", busy, 0);
    chk("t1_pass", pass, 1);
    chk("t1_smp_count", smp_count, 4);
    chk("t1_err_count", err_count, 0);
    chk("t1_ff_idx", first_fail_idx, 0);
    chk("t1_timeout", timeout, 0);
    chk("xor_err_count", x_err_count, 4);
    chk("xor_ff_idx", x_first_fail_idx, 1);
    chk("xor_ff_vec", x_first_fail_vec, 3'b001);
    chk("xor_pass", x_pass, 0);
    chk("xor_done", x_done, 1);

    // Second sample wrong for XNOR.
    pulse_start();
    chk("t2_cleared_count", smp_count, 0);
    chk("t2_cleared_done", done, 0);
    send(0, 0, 1); send(1, 0, 1); send(0, 1, 0); send(1, 1, 1);
    chk("t2_done", done, 1);
    chk("t2_err_count", err_count, 1);
    chk("t2_ff_idx", first_fail_idx, 2);
    chk("t2_ff_vec", first_fail_vec, 3'b101);
    chk("t2_pass", pass, 0);
    chk("t2_xor_err", x_err_count, 3);
    chk("t2_xor_ff_idx", x_first_fail_idx, 1);

    // Watchdog: two samples then 16 idle cycles.
    pulse_start();
    send(0, 0, 1); send(1, 1, 1);
    idle(15);
    chk("t3_not_yet", done, 0);
    chk("t3_still_busy", busy, 1);
    tick();
    chk("t3_done", done, 1);
    chk("t3_timeout", timeout, 1);
    chk("t3_smp_count", smp_count, 2);
    chk("t3_pass", pass, 0);
    chk("t3_err_count", err_count, 0);

    // A sample on the would-fire edge is accepted instead.
    pulse_start();
    idle(15);
    send(1, 0, 0);
    chk("t4_no_fire_busy", busy, 1);
    chk("t4_no_fire_timeout", timeout, 0);
    chk("t4_no_fire_count", smp_count, 1);

    // Mid-run reset discards the run.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_count", smp_count, 0);
    chk("t5_pass", pass, 0);
    pulse_start();
    send(0, 0, 1); send(1, 0, 0); send(0, 1, 0); send(1, 1, 1);
    chk("t5_rerun_pass", pass, 1);
    chk("t5_rerun_count", smp_count, 4);

    // start with smp_valid in DONE: start wins, sample not counted.
    start = 1'b1;
    smp_valid = 1'b1; smp_a = 1'b1; smp_b = 1'b0; smp_y = 1'b1;
    tick();
    start = 1'b0;
    smp_valid = 1'b0;
    chk("t6_busy", busy, 1);
    chk("t6_count", smp_count, 0);
    chk("t6_err", err_count, 0);
    chk("t6_done", done, 0);

    // start during RUN is ignored.
    pulse_start();
    send(0, 1, 1);
    chk("t7_count", smp_count, 1);
    chk("t7_err", err_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
    $finish;
  end

endmodule
